// File: rtl/add_requester_pkg.sv
// add_req_pkg: FSM states and defaults shared by the adder requester and the adder node config.
package add_req_pkg;
   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RESULT, REPORT} state_t;
   localparam logic [3:0] ADDER_DEST_DEF = 4'h1;
   localparam int TIMEOUT_DEF = 256;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/add_requester_if.sv
// add_requester_if: AXI-Stream link between the requester and its NoC leaf port.
interface add_requester_if #(parameter int TDATAW = 32, parameter int TDESTW = 4, parameter int TIDW = 2);
   logic              TVALID;
   logic              TREADY;
   logic [TDATAW-1:0] TDATA;
   logic              TLAST;
   logic [TIDW-1:0]   TID;
   logic [TDESTW-1:0] TDEST;
   modport master (output TVALID, TDATA, TLAST, TID, TDEST, input TREADY);
   modport slave (input TVALID, TDATA, TLAST, TID, TDEST, output TREADY);
endinterface

// File: rtl/add_requester_sat_cnt.sv
// add_req_sat_cnt: 16-bit event counter that sticks at all-ones instead of wrapping.
module add_req_sat_cnt
   import add_req_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) cnt <= '0;
      else if (inc && cnt != CNT_MAX) cnt <= cnt + 1'b1;
endmodule

// File: rtl/add_requester.sv
// add_requester: sends an operand pair to the NoC adder node as a two-beat packet,
// checks the returned sum against a local A+B and reports pass/fail/timeout.
module add_requester
   import add_req_pkg::*;
#(
   parameter int TDATAW = 32,
   parameter int TDESTW = 4,
   parameter int TIDW = 2,
   parameter logic [TDESTW-1:0] ADDER_DEST = TDESTW'(ADDER_DEST_DEF),
   parameter logic [TIDW-1:0] SRC_ID = '0,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [TDATAW-1:0] CMD_A,
   input  logic [TDATAW-1:0] CMD_B,
   output logic              RSP_VALID,
   output logic [TDATAW-1:0] RSP_DATA,
   output logic              RSP_PASS,
   output logic              RSP_TIMEOUT,
   output logic [CNT_W-1:0]  PASS_CNT,
   output logic [CNT_W-1:0]  FAIL_CNT,
   add_requester_if.master   AXIS_M,
   add_requester_if.slave    AXIS_S
);
   localparam int TO_W = $clog2(TIMEOUT);
   state_t            state;
   logic [TDATAW-1:0] opb, exp_sum, m_tdata;
   logic [TO_W-1:0]   tcnt;
   logic              m_tvalid, m_tlast, s_tready;
   logic [TIDW-1:0]   m_tid;
   logic [TDESTW-1:0] m_tdest;
   assign AXIS_M.TVALID = m_tvalid;
   assign AXIS_M.TDATA  = m_tdata;
   assign AXIS_M.TLAST  = m_tlast;
   assign AXIS_M.TID    = m_tid;
   assign AXIS_M.TDEST  = m_tdest;
   assign AXIS_S.TREADY = s_tready;
   // m_tdata doubles as the A operand register: it is loaded once and held until the beat goes
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state       <= IDLE;
         CMD_READY   <= 1'b1;
         m_tvalid    <= 1'b0;
         m_tdata     <= '0;
         m_tlast     <= 1'b0;
         m_tid       <= '0;
         m_tdest     <= '0;
         s_tready    <= 1'b0;
         opb         <= '0;
         exp_sum     <= '0;
         tcnt        <= '0;
         RSP_VALID   <= 1'b0;
         RSP_DATA    <= '0;
         RSP_PASS    <= 1'b0;
         RSP_TIMEOUT <= 1'b0;
      end else begin
         RSP_VALID <= 1'b0;
         case (state)
            IDLE: if (CMD_VALID) begin
               opb       <= CMD_B;
               exp_sum   <= CMD_A + CMD_B;
               CMD_READY <= 1'b0;
               m_tvalid  <= 1'b1;
               m_tdata   <= CMD_A;
               m_tlast   <= 1'b0;
               m_tid     <= SRC_ID;
               m_tdest   <= ADDER_DEST;
               state     <= SEND_A;
            end
            SEND_A: if (AXIS_M.TREADY) begin
               m_tdata <= opb;
               m_tlast <= 1'b1;
               state   <= SEND_B;
            end
            SEND_B: if (AXIS_M.TREADY) begin
               m_tvalid <= 1'b0;
               m_tdata  <= '0;
               m_tlast  <= 1'b0;
               m_tid    <= '0;
               m_tdest  <= '0;
               s_tready <= 1'b1;
               tcnt     <= '0;
               state    <= WAIT_RESULT;
            end
            WAIT_RESULT: if (AXIS_S.TVALID || tcnt == TO_W'(TIMEOUT - 1)) begin
               // a result arriving on the last allowed cycle still counts as a result
               RSP_DATA    <= AXIS_S.TVALID ? AXIS_S.TDATA : '0;
               RSP_PASS    <= AXIS_S.TVALID && AXIS_S.TLAST && AXIS_S.TDATA == exp_sum;
               RSP_TIMEOUT <= !AXIS_S.TVALID;
               RSP_VALID   <= 1'b1;
               s_tready    <= 1'b0;
               state       <= REPORT;
            end else tcnt <= tcnt + 1'b1;
            REPORT: begin
               CMD_READY <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   add_req_sat_cnt u_pass_cnt (.CLK(CLK), .RST_N(RST_N), .inc(RSP_VALID && RSP_PASS), .cnt(PASS_CNT));
   add_req_sat_cnt u_fail_cnt (.CLK(CLK), .RST_N(RST_N), .inc(RSP_VALID && !RSP_PASS), .cnt(FAIL_CNT));
endmodule

// File: tb/tb_add_requester.sv
// tb_add_requester: directed stimulus with queued expectations checked by separate beat/result monitors.
module tb_add_requester;
   typedef struct {logic [31:0] data; logic pass; logic to;} rsp_t;
   typedef struct {logic [31:0] data; logic last;} beat_t;
   logic CLK = 0, RST_N = 0, CMD_VALID = 0, CMD_READY, RSP_VALID, RSP_PASS, RSP_TIMEOUT;
   logic [31:0] CMD_A = 0, CMD_B = 0, RSP_DATA;
   logic [15:0] PASS_CNT, FAIL_CNT;
   int total = 0, bad = 0, pc = 0, fc = 0;
   rsp_t  exp_rsp[$];
   beat_t exp_beats[$];
   logic prev_stall = 0, prev_last = 0;
   logic [31:0] prev_data = 0;
   add_requester_if m_if ();
   add_requester_if s_if ();
   add_requester #(.TIMEOUT(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_A(CMD_A), .CMD_B(CMD_B), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
      .RSP_PASS(RSP_PASS), .RSP_TIMEOUT(RSP_TIMEOUT), .PASS_CNT(PASS_CNT),
      .FAIL_CNT(FAIL_CNT), .AXIS_M(m_if), .AXIS_S(s_if));
   always #5 CLK = ~CLK;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask
   task automatic timed_out(input string nm);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired", nm);
   endtask
   always @(negedge CLK) begin
      if (RSP_VALID) begin
         if (exp_rsp.size() == 0) timed_out("rsp_unexpected");
         else begin
            chk("rsp_data", RSP_DATA, exp_rsp[0].data);
            chk("rsp_pass", 32'(RSP_PASS), 32'(exp_rsp[0].pass));
            chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(exp_rsp[0].to));
            void'(exp_rsp.pop_front());
         end
      end
      if (m_if.TVALID && m_if.TREADY) begin
         if (exp_beats.size() == 0) timed_out("beat_unexpected");
         else begin
            chk("beat_data", m_if.TDATA, exp_beats[0].data);
            chk("beat_last", 32'(m_if.TLAST), 32'(exp_beats[0].last));
            chk("beat_dest", 32'(m_if.TDEST), 32'h1);
            chk("beat_id", 32'(m_if.TID), 32'h0);
            void'(exp_beats.pop_front());
         end
      end
      if (prev_stall && RST_N) begin
         chk("stall_valid", 32'(m_if.TVALID), 32'h1);
         chk("stall_data", m_if.TDATA, prev_data);
         chk("stall_last", 32'(m_if.TLAST), 32'(prev_last));
      end
      prev_stall <= RST_N && m_if.TVALID && !m_if.TREADY;
      prev_data  <= m_if.TDATA;
      prev_last  <= m_if.TLAST;
   end
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!CMD_READY && n < 100) begin tick(); n++; end
      if (!CMD_READY) timed_out("cmd_ready_wait");
      CMD_VALID = 1; CMD_A = a; CMD_B = b;
      exp_beats.push_back('{a, 1'b0});
      exp_beats.push_back('{b, 1'b1});
      tick();
      CMD_VALID = 0;
   endtask
   task automatic wait_sready();
      int n = 0;
      while (!s_if.TREADY && n < 100) begin tick(); n++; end
      if (!s_if.TREADY) timed_out("s_tready_wait");
   endtask
   task automatic respond(input logic [31:0] d, input logic last, input int delay);
      wait_sready();
      repeat (delay) tick();
      s_if.TVALID = 1; s_if.TDATA = d; s_if.TLAST = last;
      tick();
      s_if.TVALID = 0;
   endtask
   task automatic wait_rsp(output int n);
      n = 0;
      while (!RSP_VALID && n < 100) begin tick(); n++; end
      if (!RSP_VALID) timed_out("rsp_wait");
      tick();
      chk("pass_cnt", 32'(PASS_CNT), 32'(pc));
      chk("fail_cnt", 32'(FAIL_CNT), 32'(fc));
   endtask
   task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                      input logic last, input logic pass);
      int n;
      exp_rsp.push_back('{r, pass, 1'b0});
      if (pass) pc++; else fc++;
      send_cmd(a, b);
      respond(r, last, 0);
      wait_rsp(n);
   endtask
   initial begin
      int n;
      m_if.TREADY = 1;
      s_if.TVALID = 0; s_if.TDATA = 0; s_if.TLAST = 0; s_if.TID = 0; s_if.TDEST = 0;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1;
      chk("reset_cmd_ready", 32'(CMD_READY), 32'h1);
      chk("reset_m_tvalid", 32'(m_if.TVALID), 32'h0);
      chk("reset_s_tready", 32'(s_if.TREADY), 32'h0);
      chk("reset_rsp_valid", 32'(RSP_VALID), 32'h0);
      chk("reset_cnts", {PASS_CNT, FAIL_CNT}, 32'h0);
      txn(32'd5, 32'd7, 32'd12, 1'b1, 1'b1);
      txn(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1);
      txn(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1, 1'b0);
      m_if.TREADY = 0;
      exp_rsp.push_back('{32'd123, 1'b1, 1'b0}); pc++;
      send_cmd(32'd100, 32'd23);
      repeat (3) tick();
      m_if.TREADY = 1;
      tick();
      m_if.TREADY = 0;
      repeat (2) tick();
      m_if.TREADY = 1;
      respond(32'd123, 1'b1, 0);
      wait_rsp(n);
      chk("bp_beats_left", 32'(exp_beats.size()), 32'h0);
      exp_rsp.push_back('{32'd0, 1'b0, 1'b1}); fc++;
      send_cmd(32'd1, 32'd1);
      wait_sready();
      wait_rsp(n);
      chk("timeout_cycles", 32'(n), 32'd16);
      s_if.TVALID = 1; s_if.TDATA = 32'd30; s_if.TLAST = 1;
      for (int i = 0; i < 3; i++) begin
         chk("stray_held_off", 32'(s_if.TREADY), 32'h0);
         tick();
      end
      exp_rsp.push_back('{32'd30, 1'b1, 1'b0}); pc++;
      send_cmd(32'd10, 32'd20);
      respond(32'd30, 1'b1, 0);
      wait_rsp(n);
      exp_rsp.push_back('{32'd7, 1'b1, 1'b0}); pc++;
      send_cmd(32'd3, 32'd4);
      respond(32'd7, 1'b1, 15);
      wait_rsp(n);
      txn(32'd8, 32'd9, 32'd17, 1'b0, 1'b0);
      m_if.TREADY = 0;
      send_cmd(32'h11, 32'h22);
      m_if.TREADY = 1;
      tick();
      m_if.TREADY = 0;
      tick();
      #2 RST_N = 0;
      #1;
      chk("rst_m_tvalid", 32'(m_if.TVALID), 32'h0);
      chk("rst_cmd_ready", 32'(CMD_READY), 32'h1);
      chk("rst_cnts", {PASS_CNT, FAIL_CNT}, 32'h0);
      exp_beats.delete();
      pc = 0; fc = 0;
      tick();
      RST_N = 1;
      m_if.TREADY = 1;
      txn(32'd40, 32'd2, 32'd42, 1'b1, 1'b1);
      repeat (3) tick();
      chk("beats_left", 32'(exp_beats.size()), 32'h0);
      chk("rsps_left", 32'(exp_rsp.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
